pipeline_stage_chain: RTL and testbench

PIPELINE_STAGE_CHAIN -- requirements
Module: pipeline_stage_chain

---
 rtl/pipeline_stage_chain.sv | 120 ++++++++++++
 tb/tb_pipeline_stage_chain.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_chain.sv
// In-order pipeline of NUM_STAGES payload registers with per-stage stall and
// flush, plus saturating bubble and retire statistics counters.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   in_valid/in_data/in_ready   decode-side handshake into stage 0
//   stall_in[k]     stage k occupant must not advance (propagates backwards)
//   flush_in[k]     kill stage k contents at the next edge
//   clr_cnt_in      synchronous clear of both counters
//   stage_valid_o / stage_data_o   per-stage state
//   retire_valid_o / retire_data_o last stage leaving the pipe this cycle
//   bubble_cnt_o / retire_cnt_o    saturating statistics counters
module pipeline_stage_chain #(
   parameter int unsigned NUM_STAGES = 3,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   input  logic [DATA_W-1:0]                    in_data,
   output logic                                 in_ready,
   input  logic [NUM_STAGES-1:0]                stall_in,
   input  logic [NUM_STAGES-1:0]                flush_in,
   input  logic                                 clr_cnt_in,
   output logic [NUM_STAGES-1:0]                stage_valid_o,
   output logic [NUM_STAGES-1:0][DATA_W-1:0]    stage_data_o,
   output logic                                 retire_valid_o,
   output logic [DATA_W-1:0]                    retire_data_o,
   output logic [CNT_W-1:0]                     bubble_cnt_o,
   output logic [CNT_W-1:0]                     retire_cnt_o
);

   localparam int unsigned LAST = NUM_STAGES - 1;

   logic [NUM_STAGES-1:0]             valid_q, valid_d;
   logic [NUM_STAGES-1:0][DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]                  bubble_cnt_q, bubble_cnt_d;
   logic [CNT_W-1:0]                  retire_cnt_q, retire_cnt_d;
   logic [NUM_STAGES-1:0]             hold_c;
   logic                              bubble_c;
   logic                              retire_c;

   // Hold propagates backwards: a stalled stage freezes everything behind it.
   always_comb begin
      hold_c       = '0;
      hold_c[LAST] = stall_in[LAST];
      for (int k = int'(NUM_STAGES) - 2; k >= 0; k--) begin
         hold_c[k] = stall_in[k] | hold_c[k+1];
      end
   end

   assign in_ready = ~hold_c[0];
   assign retire_c = valid_q[LAST] & ~stall_in[LAST] & ~flush_in[LAST];

   // Stage advance: hold, load from predecessor, or bubble when the
   // predecessor is held. A flushed source never propagates its valid bit,
   // and a flushed destination keeps its old data.
   always_comb begin
      valid_d  = valid_q;
      data_d   = data_q;
      bubble_c = 1'b0;
      if (!hold_c[0] && !flush_in[0]) begin
         valid_d[0] = in_valid;
         data_d[0]  = in_data;
      end
      for (int k = 1; k < int'(NUM_STAGES); k++) begin
         if (!hold_c[k] && hold_c[k-1]) begin
            valid_d[k] = 1'b0;
            if (valid_q[k-1]) begin
               bubble_c = 1'b1;
            end
         end else if (!hold_c[k] && !flush_in[k]) begin
            valid_d[k] = valid_q[k-1] & ~flush_in[k-1];
            data_d[k]  = data_q[k-1];
         end
      end
      valid_d = valid_d & ~flush_in;
   end

   // Saturating counters; clear wins over a same-cycle increment.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      retire_cnt_d = retire_cnt_q;
      if (clr_cnt_in) begin
         bubble_cnt_d = '0;
         retire_cnt_d = '0;
      end else begin
         if (bubble_c && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
         end
         if (retire_c && (retire_cnt_q != '1)) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q      <= '0;
         data_q       <= '0;
         bubble_cnt_q <= '0;
         retire_cnt_q <= '0;
      end else begin
         valid_q      <= valid_d;
         data_q       <= data_d;
         bubble_cnt_q <= bubble_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign stage_valid_o  = valid_q;
   assign stage_data_o   = data_q;
   assign retire_valid_o = retire_c;
   assign retire_data_o  = data_q[LAST];
   assign bubble_cnt_o   = bubble_cnt_q;
   assign retire_cnt_o   = retire_cnt_q;

endmodule

// File: tb/tb_pipeline_stage_chain.sv
// Self-checking bench for pipeline_stage_chain (3 stages, 16-bit data, 4-bit counters).
// A negedge monitor keeps a queue of accepted payloads and checks retirements
// against it; each test task adds its own directed checks.
module tb_pipeline_stage_chain;

   localparam int unsigned NS = 3;
   localparam int unsigned DW = 16;
   localparam int unsigned CW = 4;

   localparam logic [DW-1:0] VA = 16'hA0A0;
   localparam logic [DW-1:0] VB = 16'hB0B0;
   localparam logic [DW-1:0] VC = 16'hC0C0;
   localparam logic [DW-1:0] VD = 16'hD0D0;
   localparam logic [DW-1:0] VE = 16'hE0E0;
   localparam logic [DW-1:0] VF = 16'hF00F;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     in_valid;
   logic [DW-1:0]            in_data;
   logic                     in_ready;
   logic [NS-1:0]            stall_in;
   logic [NS-1:0]            flush_in;
   logic                     clr_cnt_in;
   logic [NS-1:0]            stage_valid_o;
   logic [NS-1:0][DW-1:0]    stage_data_o;
   logic                     retire_valid_o;
   logic [DW-1:0]            retire_data_o;
   logic [CW-1:0]            bubble_cnt_o;
   logic [CW-1:0]            retire_cnt_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit sb_en = 1'b1;
   bit lat_chk = 1'b0;

   typedef struct {
      logic [DW-1:0] d;
      int            c;
   } sb_t;
   sb_t q[$];
   sb_t e;

   pipeline_stage_chain #(.NUM_STAGES(NS), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_ready       (in_ready),
      .stall_in       (stall_in),
      .flush_in       (flush_in),
      .clr_cnt_in     (clr_cnt_in),
      .stage_valid_o  (stage_valid_o),
      .stage_data_o   (stage_data_o),
      .retire_valid_o (retire_valid_o),
      .retire_data_o  (retire_data_o),
      .bubble_cnt_o   (bubble_cnt_o),
      .retire_cnt_o   (retire_cnt_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: inputs are stable at negedge, so this sees what the next edge does.
   always @(negedge clk) begin
      if (!rst && sb_en) begin
         if (retire_valid_o) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL sb_unexpected_retire: got %h want none", retire_data_o);
            end else begin
               e = q.pop_front();
               if (retire_data_o !== e.d) begin
                  bad++;
                  $display("FAIL sb_retire_data: got %h want %h", retire_data_o, e.d);
               end
               if (lat_chk) begin
                  total++;
                  if (cyc - e.c != int'(NS)) begin
                     bad++;
                     $display("FAIL sb_latency: got %0d want %0d", cyc - e.c, NS);
                  end
               end
            end
         end
         if (in_valid && in_ready) q.push_back('{d: in_data, c: cyc});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic clr_pulse();
      clr_cnt_in = 1'b1;
      step();
      clr_cnt_in = 1'b0;
   endtask

   // Leaves C in stage 2, B in stage 1, A in stage 0.
   task automatic fill3();
      in_valid = 1'b1; in_data = VC; step();
      in_data = VB; step();
      in_data = VA; step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if (stage_valid_o !== 3'b000) begin bad++; $display("FAIL reset_valid: got %b want 000", stage_valid_o); end
      total++;
      if (stage_data_o[2] !== 16'h0000) begin bad++; $display("FAIL reset_data: got %h want 0000", stage_data_o[2]); end
      total++;
      if (bubble_cnt_o !== 4'h0 || retire_cnt_o !== 4'h0) begin
         bad++; $display("FAIL reset_cnt: got %h/%h want 0/0", bubble_cnt_o, retire_cnt_o);
      end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      total++;
      if (retire_valid_o !== 1'b0) begin bad++; $display("FAIL reset_retire: got %b want 0", retire_valid_o); end
      step();
      rst = 1'b0;
   endtask

   task automatic test_streaming();
      bit ok;
      lat_chk = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(i);
         #0;
         total++;
         if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready: got %b want 1", in_ready); end
         step();
      end
      in_valid = 1'b0;
      total++;
      if (stage_valid_o !== 3'b111 || stage_data_o[0] !== 16'h0005) begin
         bad++; $display("FAIL stream_full: got %b/%h want 111/0005", stage_valid_o, stage_data_o[0]);
      end
      drain(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL stream_drain: got %0d pending want 0", q.size()); end
      total++;
      if (retire_cnt_o !== 4'd5) begin bad++; $display("FAIL stream_retire_cnt: got %0d want 5", retire_cnt_o); end
      lat_chk = 1'b0;
   endtask

   task automatic test_mid_stall();
      bit ok;
      clr_pulse();
      fill3();
      stall_in = 3'b010; in_valid = 1'b1; in_data = VD;
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
      step();
      total++;
      if (stage_valid_o !== 3'b011 || stage_data_o[1] !== VB || stage_data_o[0] !== VA) begin
         bad++; $display("FAIL mid_hold1: got %b %h %h want 011 %h %h", stage_valid_o, stage_data_o[1], stage_data_o[0], VB, VA);
      end
      total++;
      if (bubble_cnt_o !== 4'd1) begin bad++; $display("FAIL mid_bubble1: got %0d want 1", bubble_cnt_o); end
      step();
      total++;
      if (stage_valid_o !== 3'b011 || bubble_cnt_o !== 4'd2) begin
         bad++; $display("FAIL mid_hold2: got %b/%0d want 011/2", stage_valid_o, bubble_cnt_o);
      end
      total++;
      if (retire_cnt_o !== 4'd1) begin bad++; $display("FAIL mid_retire_c: got %0d want 1", retire_cnt_o); end
      stall_in = 3'b000; in_valid = 1'b0;
      drain(ok);
      total++;
      if (!ok || retire_cnt_o !== 4'd3) begin bad++; $display("FAIL mid_drain: got %0d want 3", retire_cnt_o); end
   endtask

   task automatic test_last_stall();
      bit ok;
      clr_pulse();
      fill3();
      stall_in = 3'b100; in_valid = 1'b1; in_data = VD;
      #1;
      total++;
      if (retire_valid_o !== 1'b0 || in_ready !== 1'b0) begin
         bad++; $display("FAIL last_comb: got rv=%b rdy=%b want 0 0", retire_valid_o, in_ready);
      end
      step();
      total++;
      if (stage_valid_o !== 3'b111 || stage_data_o[2] !== VC || stage_data_o[1] !== VB || stage_data_o[0] !== VA) begin
         bad++; $display("FAIL last_hold: got %b %h %h %h want 111 %h %h %h", stage_valid_o,
                         stage_data_o[2], stage_data_o[1], stage_data_o[0], VC, VB, VA);
      end
      step();
      total++;
      if (bubble_cnt_o !== 4'd0 || retire_cnt_o !== 4'd0) begin
         bad++; $display("FAIL last_cnt: got %0d/%0d want 0/0", bubble_cnt_o, retire_cnt_o);
      end
      stall_in = 3'b000; in_valid = 1'b0;
      drain(ok);
      total++;
      if (!ok || retire_cnt_o !== 4'd3) begin bad++; $display("FAIL last_drain: got %0d want 3", retire_cnt_o); end
   endtask

   task automatic test_flush();
      sb_en = 1'b0;
      q.delete();
      clr_pulse();
      fill3();
      flush_in = 3'b011; in_valid = 1'b1; in_data = VE;
      #1;
      total++;
      if (retire_valid_o !== 1'b1 || retire_data_o !== VC) begin
         bad++; $display("FAIL flush_retire_c: got %b/%h want 1/%h", retire_valid_o, retire_data_o, VC);
      end
      step();
      flush_in = 3'b000; in_valid = 1'b0;
      total++;
      if (stage_valid_o !== 3'b000) begin bad++; $display("FAIL flush_valid: got %b want 000", stage_valid_o); end
      repeat (4) step();
      total++;
      if (retire_cnt_o !== 4'd1) begin bad++; $display("FAIL flush_no_retire: got %0d want 1", retire_cnt_o); end
      sb_en = 1'b1;
   endtask

   task automatic test_saturation();
      bit ok;
      clr_pulse();
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(16'h0100 + i);
         step();
      end
      in_valid = 1'b0;
      drain(ok);
      total++;
      if (!ok || retire_cnt_o !== 4'hF) begin bad++; $display("FAIL sat_retire: got %h want f", retire_cnt_o); end
      in_valid = 1'b1; in_data = 16'h0200;
      step();
      in_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (retire_valid_o) begin ok = 1'b1; break; end
         step();
      end
      total++;
      if (!ok) begin bad++; $display("FAIL sat_wait_retire: got timeout want retire"); end
      clr_cnt_in = 1'b1;
      step();
      clr_cnt_in = 1'b0;
      total++;
      if (retire_cnt_o !== 4'h0 || q.size() != 0) begin
         bad++; $display("FAIL sat_clr_beats_inc: got %h/%0d want 0/0", retire_cnt_o, q.size());
      end
   endtask

   task automatic test_random();
      bit ok;
      for (int i = 0; i < 60; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = DW'($urandom);
         stall_in = ($urandom_range(0, 2) == 0) ? NS'($urandom_range(0, 7)) : 3'b000;
         step();
      end
      in_valid = 1'b0; stall_in = 3'b000;
      drain(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rand_drain: got %0d pending want 0", q.size()); end
   endtask

   task automatic test_async_reset();
      bit ok;
      sb_en = 1'b0;
      q.delete();
      clr_pulse();
      fill3();
      step();
      total++;
      if (retire_cnt_o !== 4'd1) begin bad++; $display("FAIL ares_pre: got %0d want 1", retire_cnt_o); end
      #3 rst = 1'b1;
      #1;
      total++;
      if (stage_valid_o !== 3'b000 || retire_cnt_o !== 4'd0 || bubble_cnt_o !== 4'd0) begin
         bad++; $display("FAIL ares_clear: got %b/%0d/%0d want 000/0/0", stage_valid_o, retire_cnt_o, bubble_cnt_o);
      end
      total++;
      if (stage_data_o[1] !== 16'h0000 || in_ready !== 1'b1) begin
         bad++; $display("FAIL ares_data: got %h/%b want 0000/1", stage_data_o[1], in_ready);
      end
      step();
      rst = 1'b0;
      sb_en = 1'b1;
      lat_chk = 1'b1;
      in_valid = 1'b1; in_data = VF;
      step();
      in_valid = 1'b0;
      total++;
      if (stage_valid_o !== 3'b001) begin bad++; $display("FAIL ares_restart: got %b want 001", stage_valid_o); end
      drain(ok);
      total++;
      if (!ok || retire_cnt_o !== 4'd1) begin bad++; $display("FAIL ares_after: got %0d want 1", retire_cnt_o); end
      lat_chk = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0;
      stall_in = '0; flush_in = '0; clr_cnt_in = 1'b0;
      test_reset();
      test_streaming();
      test_mid_stall();
      test_last_stall();
      test_flush();
      test_saturation();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
